// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator with rotate, bounce and
// fill/drain modes, synchronous load and advance-enable.
module led_pattern_gen #(
    parameter int unsigned     WIDTH = 8,
    parameter int unsigned     DIV_W = 24,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] po_a,
    output logic             step,
    output logic             dir
);

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ROL    = 2'd0,
        MODE_ROR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             dir_q, dir_d;
    logic             phase_q, phase_d;
    logic             step_q, step_d;

    logic [WIDTH-1:0] adv_pat;
    logic             adv_dir;
    logic             adv_phase;
    logic             step_due;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);
    assign step_due = en && (cnt_q >= div);

    // Pattern value, bounce direction and fill phase after one step in the current mode.
    always_comb begin
        adv_pat   = pat_q;
        adv_dir   = dir_q;
        adv_phase = phase_q;
        case (mode_sel)
            MODE_ROL: adv_pat = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
            MODE_ROR: adv_pat = {pat_q[0], pat_q[WIDTH-1:1]};
            MODE_BOUNCE: begin
                if (pat_q == '0) begin
                    // nothing left to bounce; restart from the seed
                    adv_pat = SEED;
                    adv_dir = 1'b0;
                end else if (!dir_q && pat_q[WIDTH-1]) begin
                    adv_dir = 1'b1;
                    adv_pat = pat_q >> 1;
                end else if (dir_q && pat_q[0]) begin
                    adv_dir = 1'b0;
                    adv_pat = pat_q << 1;
                end else begin
                    adv_pat = dir_q ? (pat_q >> 1) : (pat_q << 1);
                end
            end
            MODE_FILL: begin
                if (!phase_q && (&pat_q)) begin
                    adv_phase = 1'b1;
                    adv_pat   = {1'b0, pat_q[WIDTH-1:1]};
                end else if (phase_q && (pat_q == '0)) begin
                    adv_phase = 1'b0;
                    adv_pat   = {pat_q[WIDTH-2:0], 1'b1};
                end else if (phase_q) begin
                    adv_pat = {1'b0, pat_q[WIDTH-1:1]};
                end else begin
                    adv_pat = {pat_q[WIDTH-2:0], 1'b1};
                end
            end
            default: adv_pat = pat_q;
        endcase
    end

    // Next-state selection: load beats a due step; en=0 freezes everything but clears step.
    always_comb begin
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        step_d  = 1'b0;
        if (load) begin
            pat_d   = load_val;
            cnt_d   = '0;
            dir_d   = 1'b0;
            phase_d = 1'b0;
        end else if (step_due) begin
            cnt_d   = '0;
            step_d  = 1'b1;
            pat_d   = adv_pat;
            dir_d   = adv_dir;
            phase_d = adv_phase;
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pat_q   <= SEED;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

    assign po_a = pat_q;
    assign step = step_q;
    assign dir  = dir_q;

endmodule
